// File: rtl/sgen_fcw_sweep_pkg.sv
// Shared types and constants for the FCW sweep generator.
package sgen_fcw_sweep_pkg;

    // Sweep controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } sweep_state_t;

    // Sweep mode encodings (2'b11 behaves as single)
    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_SAW    = 2'b01;
    localparam logic [1:0] MODE_TRI    = 2'b10;

endpackage

// File: rtl/sgen_dwell_cnt.sv
// Dwell counter: counts enabled cycles while running, flags the last
// cycle of a dwell (cnt == i_dwell) and wraps to zero on that cycle.
module sgen_dwell_cnt #(
    parameter int gp_dwell_width = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_an,
    input  logic                      i_ena,
    input  logic                      i_clr,
    input  logic                      i_run,
    input  logic [gp_dwell_width-1:0] i_dwell,
    output logic [gp_dwell_width-1:0] o_cnt,
    output logic                      o_tc
);

    assign o_tc = (o_cnt == i_dwell);

    // Clear has priority; otherwise count while running and wrap at terminal count
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            o_cnt <= '0;
        end else if (i_ena) begin
            if (i_clr) begin
                o_cnt <= '0;
            end else if (i_run) begin
                o_cnt <= o_tc ? '0 : o_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sgen_fcw_sweep.sv
// FCW sweep generator feeding sgen_nco: steps an unsigned FCW from start to
// stop with a programmable dwell per value, for single, sawtooth-repeat and
// triangle-repeat chirps. A zero step gives a CW tone at the start value.
//
// Control handshake: i_start is a request that is taken only on an enabled
// cycle while o_busy is low (o_busy acts as "not ready"); a request seen
// while o_busy is high is dropped, not queued. i_stop on an enabled cycle
// always wins and returns the block to idle.
module sgen_fcw_sweep
    import sgen_fcw_sweep_pkg::*;
#(
    parameter int gp_phase_accu_width = 16,
    parameter int gp_dwell_width      = 8
) (
    input  logic                           i_clk,
    input  logic                           i_rst_an,
    input  logic                           i_ena,
    input  logic                           i_start,
    input  logic                           i_stop,
    input  logic [1:0]                     i_mode,
    input  logic [gp_phase_accu_width-1:0] i_fcw_start,
    input  logic [gp_phase_accu_width-1:0] i_fcw_stop,
    input  logic [gp_phase_accu_width-1:0] i_fcw_step,
    input  logic [gp_dwell_width-1:0]      i_dwell,
    output logic [gp_phase_accu_width-1:0] o_fcw,
    output logic                           o_busy,
    output logic                           o_done,
    output logic [1:0]                     o_dbg_state
);

    localparam int W = gp_phase_accu_width;
    localparam int D = gp_dwell_width;

    sweep_state_t  state_q;
    logic [1:0]    mode_q;
    logic [W-1:0]  start_q;
    logic [W-1:0]  stop_q;
    logic [W-1:0]  step_q;
    logic [D-1:0]  dwell_q;
    logic          dir_up_q;

    logic          cnt_clr;
    logic          cnt_run;
    logic [D-1:0]  cnt;
    logic          cnt_tc;

    logic          start_ok;
    logic [W-1:0]  fcw_fwd;
    logic [W-1:0]  fcw_rev;

    // One step from cur toward lim in W+1 bits, clamped at lim so it never
    // overshoots or wraps around the FCW range.
    function automatic logic [W-1:0] step_clamp(
        input logic [W-1:0] cur,
        input logic [W-1:0] step,
        input logic [W-1:0] lim,
        input logic         up
    );
        logic [W:0] s;
        if (up) begin
            s = {1'b0, cur} + {1'b0, step};
            step_clamp = (s > {1'b0, lim}) ? lim : s[W-1:0];
        end else begin
            s = {1'b0, cur} - {1'b0, step};
            step_clamp = (s[W] || (s[W-1:0] < lim)) ? lim : s[W-1:0];
        end
    endfunction

    assign o_dbg_state = state_q;
    assign start_ok    = (state_q == ST_IDLE) && i_start && !i_stop;
    assign cnt_clr     = i_stop || start_ok;
    assign cnt_run     = (state_q == ST_SWEEP);

    // Forward step toward stop, and reversed step back toward start for triangle turnaround
    always_comb begin
        fcw_fwd = step_clamp(o_fcw, step_q, stop_q, dir_up_q);
        fcw_rev = step_clamp(o_fcw, step_q, start_q, !dir_up_q);
    end

    sgen_dwell_cnt #(
        .gp_dwell_width (D)
    ) u_dwell_cnt (
        .i_clk    (i_clk),
        .i_rst_an (i_rst_an),
        .i_ena    (i_ena),
        .i_clr    (cnt_clr),
        .i_run    (cnt_run),
        .i_dwell  (dwell_q),
        .o_cnt    (cnt),
        .o_tc     (cnt_tc)
    );

    // Sweep FSM with registered outputs and latched configuration
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            state_q  <= ST_IDLE;
            mode_q   <= '0;
            start_q  <= '0;
            stop_q   <= '0;
            step_q   <= '0;
            dwell_q  <= '0;
            dir_up_q <= 1'b0;
            o_fcw    <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else if (i_ena) begin
            if (i_stop) begin
                state_q <= ST_IDLE;
                o_fcw   <= '0;
                o_busy  <= 1'b0;
                o_done  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        o_done <= 1'b0;
                        if (i_start) begin
                            mode_q   <= i_mode;
                            start_q  <= i_fcw_start;
                            stop_q   <= i_fcw_stop;
                            step_q   <= i_fcw_step;
                            dwell_q  <= i_dwell;
                            dir_up_q <= (i_fcw_stop >= i_fcw_start);
                            o_fcw    <= i_fcw_start;
                            o_busy   <= 1'b1;
                            state_q  <= ST_SWEEP;
                        end
                    end
                    ST_SWEEP: begin
                        // A zero step is a CW tone: never advance, never finish
                        if (cnt_tc && (step_q != '0)) begin
                            if (o_fcw == stop_q) begin
                                case (mode_q)
                                    MODE_SAW: begin
                                        o_fcw <= start_q;
                                    end
                                    MODE_TRI: begin
                                        o_fcw    <= fcw_rev;
                                        start_q  <= stop_q;
                                        stop_q   <= start_q;
                                        dir_up_q <= !dir_up_q;
                                    end
                                    default: begin
                                        o_done  <= 1'b1;
                                        state_q <= ST_DONE;
                                    end
                                endcase
                            end else begin
                                o_fcw <= fcw_fwd;
                            end
                        end
                    end
                    ST_DONE: begin
                        o_done  <= 1'b0;
                        o_busy  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sgen_fcw_sweep.sv
// Directed bench for sgen_fcw_sweep: hand-computed FCW sequences are queued
// and compared cycle by cycle, plus reset, abort, enable-freeze and clamp cases.
module tb_sgen_fcw_sweep;

    localparam int W = 16;
    localparam int D = 8;

    logic         clk;
    logic         rst_n;
    logic         ena;
    logic         start;
    logic         stop;
    logic [1:0]   mode;
    logic [W-1:0] fcw_start;
    logic [W-1:0] fcw_stop;
    logic [W-1:0] fcw_step;
    logic [D-1:0] dwell;
    logic [W-1:0] fcw;
    logic         busy;
    logic         done;
    logic [1:0]   dbg_state;

    logic [W-1:0] exp_q[$];
    int           n_vec;
    int           n_err;

    sgen_fcw_sweep #(
        .gp_phase_accu_width (W),
        .gp_dwell_width      (D)
    ) dut (
        .i_clk       (clk),
        .i_rst_an    (rst_n),
        .i_ena       (ena),
        .i_start     (start),
        .i_stop      (stop),
        .i_mode      (mode),
        .i_fcw_start (fcw_start),
        .i_fcw_stop  (fcw_stop),
        .i_fcw_step  (fcw_step),
        .i_dwell     (dwell),
        .o_fcw       (fcw),
        .o_busy      (busy),
        .o_done      (done),
        .o_dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; sample/drive 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rep(input logic [W-1:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    // Compare queued FCW values one per cycle; o_done must stay low meanwhile
    task automatic run_seq(input string tag);
        logic [W-1:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_fcw"}, 32'(fcw), 32'(e));
            chk({tag, "_done_lo"}, 32'(done), 32'd0);
            tick();
        end
    endtask

    task automatic kick(input logic [1:0] m, input logic [W-1:0] s0, input logic [W-1:0] s1,
                        input logic [W-1:0] st, input logic [D-1:0] dw);
        mode      = m;
        fcw_start = s0;
        fcw_stop  = s1;
        fcw_step  = st;
        dwell     = dw;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic abort();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        ena       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        mode      = 2'b00;
        fcw_start = '0;
        fcw_stop  = '0;
        fcw_step  = '0;
        dwell     = '0;

        // Reset state
        tick();
        tick();
        chk("rst_fcw", 32'(fcw), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        tick();

        // T1: single up 100..130 step 10, each value 4 cycles
        kick(2'b00, 16'd100, 16'd130, 16'd10, 8'd3);
        chk("t1_busy", 32'(busy), 32'd1);
        push_rep(16'd100, 4);
        push_rep(16'd110, 4);
        push_rep(16'd120, 4);
        push_rep(16'd130, 4);
        run_seq("t1");
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_done_fcw", 32'(fcw), 32'd130);
        tick();
        chk("t1_done_end", 32'(done), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_hold_fcw", 32'(fcw), 32'd130);
        tick();
        chk("t1_no_redone", 32'(done), 32'd0);

        // T2: down with clamp at 975, mode 11 behaves as single
        kick(2'b11, 16'd1000, 16'd975, 16'd10, 8'd0);
        push_rep(16'd1000, 1);
        push_rep(16'd990, 1);
        push_rep(16'd980, 1);
        push_rep(16'd975, 1);
        run_seq("t2");
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_done_fcw", 32'(fcw), 32'd975);
        // o_done stretches while disabled
        ena = 1'b0;
        tick();
        tick();
        chk("t2_done_frozen", 32'(done), 32'd1);
        chk("t2_busy_frozen", 32'(busy), 32'd1);
        ena = 1'b1;
        tick();
        chk("t2_done_end", 32'(done), 32'd0);
        chk("t2_idle_busy", 32'(busy), 32'd0);

        // T3: triangle 0..20 step 10, two cycles each, never done
        kick(2'b10, 16'd0, 16'd20, 16'd10, 8'd1);
        push_rep(16'd0, 2);
        push_rep(16'd10, 2);
        push_rep(16'd20, 2);
        push_rep(16'd10, 2);
        push_rep(16'd0, 2);
        push_rep(16'd10, 2);
        push_rep(16'd20, 2);
        push_rep(16'd10, 2);
        run_seq("t3");
        abort();
        chk("t3_abort_fcw", 32'(fcw), 32'd0);
        chk("t3_abort_busy", 32'(busy), 32'd0);
        chk("t3_abort_done", 32'(done), 32'd0);

        // T4: start ignored while busy, enable freeze, stop beats start
        kick(2'b00, 16'd100, 16'd200, 16'd10, 8'd3);
        start     = 1'b1;
        fcw_start = 16'd555;
        tick();
        start     = 1'b0;
        chk("t4_busy_start_ignored", 32'(fcw), 32'd100);
        tick();
        chk("t4_cnt2", 32'(fcw), 32'd100);
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_frozen_fcw", 32'(fcw), 32'd100);
        end
        ena = 1'b1;
        tick();
        chk("t4_last_dwell", 32'(fcw), 32'd100);
        tick();
        chk("t4_advance", 32'(fcw), 32'd110);
        stop  = 1'b1;
        start = 1'b1;
        tick();
        stop  = 1'b0;
        start = 1'b0;
        chk("t4_stop_fcw", 32'(fcw), 32'd0);
        chk("t4_stop_busy", 32'(busy), 32'd0);
        chk("t4_stop_state", 32'(dbg_state), 32'd0);
        tick();
        chk("t4_stays_idle", 32'(busy), 32'd0);
        chk("t4_no_done", 32'(done), 32'd0);

        // T5a: overflow clamp at top of range
        kick(2'b00, 16'hFFF0, 16'hFFFF, 16'h0020, 8'd0);
        push_rep(16'hFFF0, 1);
        push_rep(16'hFFFF, 1);
        run_seq("t5a");
        chk("t5a_done", 32'(done), 32'd1);
        chk("t5a_fcw", 32'(fcw), 32'hFFFF);
        tick();

        // T5b: zero step is a CW tone until stopped
        kick(2'b00, 16'h1234, 16'h2000, 16'h0000, 8'd0);
        push_rep(16'h1234, 20);
        run_seq("t5b");
        chk("t5b_busy", 32'(busy), 32'd1);
        abort();
        chk("t5b_stop_fcw", 32'(fcw), 32'd0);

        // Sawtooth repeat 5..7 step 1
        kick(2'b01, 16'd5, 16'd7, 16'd1, 8'd0);
        push_rep(16'd5, 1);
        push_rep(16'd6, 1);
        push_rep(16'd7, 1);
        push_rep(16'd5, 1);
        push_rep(16'd6, 1);
        push_rep(16'd7, 1);
        push_rep(16'd5, 1);
        run_seq("saw");
        abort();

        // Async reset mid-sweep takes effect without a clock edge
        kick(2'b00, 16'd300, 16'd400, 16'd10, 8'd0);
        tick();
        chk("rst_pre_fcw", 32'(fcw), 32'd310);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_fcw", 32'(fcw), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_state", 32'(dbg_state), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_after_done", 32'(done), 32'd0);
        chk("arst_after_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
